// File: rtl/conv_seq_pkg.sv
// Shared state encoding, read-kind tags and size helpers for the conv2d job sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // Which destination a returning memory byte belongs to.
    typedef enum logic [1:0] {
        RD_WGT  = 2'd0,
        RD_BIAS = 2'd1,
        RD_PIX  = 2'd2
    } rd_kind_e;

    function automatic int calc_nw(input int cout, input int cin, input int k);
        return cout * cin * k * k;
    endfunction

    function automatic int calc_nb(input int cout, input int bias_w);
        return cout * bias_w / 8;
    endfunction

    function automatic int calc_n(input int cin, input int h, input int w);
        return cin * h * w;
    endfunction

    function automatic int calc_out_total(input int cout, input int h, input int w);
        return cout * h * w;
    endfunction

    // LSB position of weight byte j inside the flat kernel vector.
    function automatic int kernel_lane_lsb(input int j, input int data_w);
        return j * data_w;
    endfunction

    // LSB position of bias byte b inside the flat bias vector (little-endian per bias).
    function automatic int bias_lane_lsb(input int b);
        return b * 8;
    endfunction

endpackage

// File: rtl/conv2d_cfg_capture.sv
// Holds the engine's kernel and bias registers, written one byte at a time by index.
module conv2d_cfg_capture
    import conv_seq_pkg::*;
#(
    parameter int NKB    = 216,
    parameter int NBB    = 16,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_bias,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [NKB*DATA_W-1:0] kernel,
    output logic [NBB*8-1:0]      bias
);

    // Byte-lane write into kernel or bias; only the addressed lane changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel <= '0;
            bias   <= '0;
        end else if (wr_en) begin
            if (wr_bias) begin
                for (int b = 0; b < NBB; b++) begin
                    if (wr_idx == IDX_W'(b))
                        bias[bias_lane_lsb(b) +: 8] <= wr_data[7:0];
                end
            end else begin
                for (int j = 0; j < NKB; j++) begin
                    if (wr_idx == IDX_W'(j))
                        kernel[kernel_lane_lsb(j, DATA_W) +: DATA_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/conv2d_job_sequencer.sv
// Job sequencer for the conv2d engine: loads weights/biases, streams the frame, tracks completion.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// LOAD_W   | reading NW kernel bytes from wgt_base
// LOAD_B   | reading NB bias bytes from wgt_base+NW
// STREAM   | reading N frame bytes from img_base into the engine
// DRAIN    | waiting for engine done or idle timeout
// DONE     | one-cycle completion pulse, output count checked
module conv2d_job_sequencer
    import conv_seq_pkg::*;
#(
    parameter int CIN     = 3,
    parameter int COUT    = 8,
    parameter int K       = 3,
    parameter int H       = 64,
    parameter int W       = 64,
    parameter int DATA_W  = 8,
    parameter int BIAS_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              img_base,
    input  logic [ADDR_W-1:0]              wgt_base,
    input  logic                           src_hold,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_rd_data,
    output logic [COUT*CIN*K*K*DATA_W-1:0] kernel,
    output logic [COUT*BIAS_W-1:0]         bias,
    output logic [DATA_W-1:0]              eng_pixel,
    output logic                           eng_valid,
    output logic                           eng_last,
    input  logic                           eng_valid_out,
    input  logic                           eng_done,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               out_count,
    output logic                           err_timeout,
    output logic                           err_count
);

    localparam int NW        = calc_nw(COUT, CIN, K);
    localparam int NB        = calc_nb(COUT, BIAS_W);
    localparam int N         = calc_n(CIN, H, W);
    localparam int OUT_TOTAL = calc_out_total(COUT, H, W);
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD_W = ST_LOAD_W;
    localparam logic [2:0] S_LOAD_B = ST_LOAD_B;
    localparam logic [2:0] S_STREAM = ST_STREAM;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;
    localparam logic [2:0] S_DONE   = ST_DONE;

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] img_base_q;
    logic [ADDR_W-1:0] wgt_base_q;
    logic              rd_vld_q;
    rd_kind_e          rd_kind_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic              rd_last_q;
    logic [TO_W-1:0]   idle_left_q;

    logic              reading;
    logic              rd_issue;
    logic              idx_at_end;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] last_idx;
    rd_kind_e          cur_kind;
    logic              timeout_hit;

    // Per-state read address, final index and destination of the byte being fetched.
    always_comb begin
        reading  = 1'b0;
        rd_addr  = '0;
        last_idx = '0;
        cur_kind = RD_PIX;
        case (state_q)
            S_LOAD_W: begin
                reading  = 1'b1;
                rd_addr  = wgt_base_q + idx_q;
                last_idx = ADDR_W'(NW - 1);
                cur_kind = RD_WGT;
            end
            S_LOAD_B: begin
                reading  = 1'b1;
                rd_addr  = wgt_base_q + ADDR_W'(NW) + idx_q;
                last_idx = ADDR_W'(NB - 1);
                cur_kind = RD_BIAS;
            end
            S_STREAM: begin
                reading  = 1'b1;
                rd_addr  = img_base_q + idx_q;
                last_idx = ADDR_W'(N - 1);
                cur_kind = RD_PIX;
            end
            default: ;
        endcase
    end

    assign rd_issue    = reading && !src_hold;
    assign idx_at_end  = (idx_q == last_idx);
    assign mem_rd_en   = rd_issue;
    assign mem_addr    = rd_issue ? rd_addr : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    // eng_done has priority over a timeout expiring in the same cycle.
    assign timeout_hit = (state_q == S_DRAIN) && !eng_done && !eng_valid_out && (idle_left_q == '0);

    // Main FSM with shared read index; a held cycle neither reads nor advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            img_base_q <= '0;
            wgt_base_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        img_base_q <= img_base;
                        wgt_base_q <= wgt_base;
                        idx_q      <= '0;
                        state_q    <= S_LOAD_W;
                    end
                end
                S_LOAD_W, S_LOAD_B, S_STREAM: begin
                    if (rd_issue) begin
                        if (idx_at_end) begin
                            idx_q <= '0;
                            if (state_q == S_LOAD_W)
                                state_q <= S_LOAD_B;
                            else if (state_q == S_LOAD_B)
                                state_q <= S_STREAM;
                            else
                                state_q <= S_DRAIN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (eng_done || timeout_hit)
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag each issued read so the returning byte lands in the right place one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_kind_q <= RD_PIX;
            rd_idx_q  <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_issue;
            rd_kind_q <= cur_kind;
            rd_idx_q  <= idx_q;
            rd_last_q <= (state_q == S_STREAM) && idx_at_end;
        end
    end

    // Registered engine pixel interface; eng_pixel keeps its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_pixel <= '0;
            eng_valid <= 1'b0;
            eng_last  <= 1'b0;
        end else begin
            eng_valid <= rd_vld_q && (rd_kind_q == RD_PIX);
            eng_last  <= rd_vld_q && (rd_kind_q == RD_PIX) && rd_last_q;
            if (rd_vld_q && (rd_kind_q == RD_PIX))
                eng_pixel <= mem_rd_data;
        end
    end

    // Idle down-counter, reloaded outside DRAIN and on every engine output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_left_q <= TO_W'(TIMEOUT - 1);
        else if ((state_q != S_DRAIN) || eng_valid_out)
            idle_left_q <= TO_W'(TIMEOUT - 1);
        else if (idle_left_q != '0)
            idle_left_q <= idle_left_q - 1'b1;
    end

    // Output counter and sticky error flags, cleared when a job is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count   <= '0;
            err_timeout <= 1'b0;
            err_count   <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            out_count   <= '0;
            err_timeout <= 1'b0;
            err_count   <= 1'b0;
        end else begin
            if (((state_q == S_STREAM) || (state_q == S_DRAIN)) && eng_valid_out && (out_count != '1))
                out_count <= out_count + 1'b1;
            if (timeout_hit)
                err_timeout <= 1'b1;
            if (state_q == S_DONE)
                err_count <= (out_count != CNT_W'(OUT_TOTAL));
        end
    end

    conv2d_cfg_capture #(
        .NKB    (NW),
        .NBB    (NB),
        .DATA_W (DATA_W),
        .IDX_W  (ADDR_W)
    ) u_cfg_capture (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rd_vld_q && (rd_kind_q != RD_PIX)),
        .wr_bias (rd_kind_q == RD_BIAS),
        .wr_idx  (rd_idx_q),
        .wr_data (mem_rd_data),
        .kernel  (kernel),
        .bias    (bias)
    );

endmodule

// File: tb/tb_conv2d_job_sequencer.sv
// Directed bench for conv2d_job_sequencer with a byte memory and a simple engine model.
module tb_conv2d_job_sequencer;

    localparam int CIN = 3, COUT = 8, K = 3, H = 64, W = 64;
    localparam int DATA_W = 8, BIAS_W = 16, ADDR_W = 16, TIMEOUT = 4096, CNT_W = 16;
    localparam int NW = 216;
    localparam int NB = 16;
    localparam int N  = 12288;
    localparam int KW = NW * DATA_W;
    localparam int BW = COUT * BIAS_W;
    localparam logic [15:0] IMG_BASE = 16'h1000;
    localparam logic [15:0] WGT_BASE = 16'h0100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       img_base = '0;
    logic [15:0]       wgt_base = '0;
    logic              src_hold = 1'b0;
    logic              mem_rd_en;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_rd_data = '0;
    logic [KW-1:0]     kernel;
    logic [BW-1:0]     bias;
    logic [7:0]        eng_pixel;
    logic              eng_valid;
    logic              eng_last;
    logic              eng_valid_out = 1'b0;
    logic              eng_done = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  out_count;
    logic              err_timeout;
    logic              err_count;

    conv2d_job_sequencer #(
        .CIN(CIN), .COUT(COUT), .K(K), .H(H), .W(W), .DATA_W(DATA_W), .BIAS_W(BIAS_W),
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_base(img_base), .wgt_base(wgt_base),
        .src_hold(src_hold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .kernel(kernel), .bias(bias), .eng_pixel(eng_pixel), .eng_valid(eng_valid), .eng_last(eng_last),
        .eng_valid_out(eng_valid_out), .eng_done(eng_done), .busy(busy), .done(done),
        .out_count(out_count), .err_timeout(err_timeout), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    function automatic logic [7:0] pix_of(input int i);
        return 8'((i * 13) ^ (i >> 7));
    endfunction

    logic [KW-1:0] exp_kernel;
    logic [BW-1:0] exp_bias;

    // Controls written only by the directed sequence.
    logic clr = 1'b1;
    logic hold_en = 1'b0;
    int   eng_target = 0;
    logic eng_do_done = 1'b0;

    // Observations and engine-model state, owned by the negedge process.
    int rd_cnt, rd_first, rd_last, v_cnt, v_first, last_cnt, last_cyc;
    int pix_err, cfg_err, done_cnt, done_cyc, out_cyc, ed_cyc, emitted;
    logic [7:0] last_pix;
    logic active, done_sent;

    int tests = 0;
    int fails = 0;
    int s0 = 0;

    // Observe the DUT, then drive the engine model and source hold for the next edge.
    always @(negedge clk) begin
        if (clr) begin
            rd_cnt = 0; rd_first = 0; rd_last = 0; v_cnt = 0; v_first = 0;
            last_cnt = 0; last_cyc = 0; last_pix = '0; pix_err = 0; cfg_err = 0;
            done_cnt = 0; done_cyc = 0; out_cyc = 0; ed_cyc = 0; emitted = 0;
            active = 1'b0; done_sent = 1'b0;
            eng_valid_out = 1'b0; eng_done = 1'b0; src_hold = 1'b0;
        end else begin
            if (mem_rd_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
            end
            if (eng_valid) begin
                if (v_cnt == 0) v_first = cyc;
                if (eng_pixel !== pix_of(v_cnt)) pix_err++;
                if (eng_last !== (v_cnt == N - 1)) pix_err++;
                if ((kernel !== exp_kernel) || (bias !== exp_bias)) cfg_err++;
                v_cnt++;
            end
            if (eng_last) begin
                last_cnt++;
                last_cyc = cyc;
                last_pix = eng_pixel;
                active = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            eng_done = 1'b0;
            if (active && (emitted < eng_target)) begin
                eng_valid_out = 1'b1;
                emitted++;
                out_cyc = cyc;
            end else begin
                eng_valid_out = 1'b0;
                if (active && eng_do_done && !done_sent) begin
                    eng_done = 1'b1;
                    done_sent = 1'b1;
                    ed_cyc = cyc;
                end
            end
            src_hold = hold_en && (cyc % 3 == 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int rel(input int c);
        return c - s0 + 1;
    endfunction

    task automatic start_job(input logic [15:0] ib, input logic [15:0] wb);
        img_base = ib;
        wgt_base = wb;
        start = 1'b1;
        tick();
        start = 1'b0;
        s0 = cyc;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while ((done_cnt == 0) && (n < budget)) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_kernel_zero"}, 64'(kernel === '0), 64'd1);
        chk({tag, "_bias_zero"}, 64'(bias === '0), 64'd1);
        chk({tag, "_eng_if"}, {54'd0, eng_pixel, eng_valid, eng_last}, 64'd0);
        chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_out_count"}, 64'(out_count), 64'd0);
        chk({tag, "_errs"}, {62'd0, err_timeout, err_count}, 64'd0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int j = 0; j < NW; j++) mem[WGT_BASE + 16'(j)] = 8'(j);
        for (int b = 0; b < NB; b++) mem[WGT_BASE + 16'(NW + b)] = 8'(8'h10 + b);
        for (int i = 0; i < N; i++) mem[IMG_BASE + 16'(i)] = pix_of(i);
        for (int j = 0; j < NW; j++) exp_kernel[j*8 +: 8] = 8'(j);
        for (int b = 0; b < NB; b++) exp_bias[b*8 +: 8] = 8'(8'h10 + b);

        // Reset state
        rst_n = 1'b0;
        clr = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        clr = 1'b0;

        // Job 1: no holds, full output count, start pulse mid-stream
        hold_en = 1'b0;
        eng_target = 32768;
        eng_do_done = 1'b1;
        start_job(IMG_BASE, WGT_BASE);
        repeat (4990) tick();
        img_base = 16'hA000;
        wgt_base = 16'h3000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("j1_busy_after_restart", 64'(busy), 64'd1);
        wait_done(50000, "j1");
        chk("j1_rd_cnt", 64'(rd_cnt), 64'd12520);
        chk("j1_rd_first", 64'(rel(rd_first)), 64'd1);
        chk("j1_rd_last", 64'(rel(rd_last)), 64'd12520);
        chk("j1_first_valid", 64'(rel(v_first)), 64'd235);
        chk("j1_last_cyc", 64'(rel(last_cyc)), 64'd12522);
        chk("j1_last_cnt", 64'(last_cnt), 64'd1);
        chk("j1_last_pix", 64'(last_pix), 64'(pix_of(N - 1)));
        chk("j1_valid_cnt", 64'(v_cnt), 64'd12288);
        chk("j1_pix_err", 64'(pix_err), 64'd0);
        chk("j1_cfg_err", 64'(cfg_err), 64'd0);
        chk("j1_kernel", 64'(kernel === exp_kernel), 64'd1);
        chk("j1_kernel_byte_d7", 64'(kernel[215*8 +: 8]), 64'hD7);
        chk("j1_bias_lo", 64'(bias[15:0]), 64'h1110);
        chk("j1_bias_all", 64'(bias === exp_bias), 64'd1);
        chk("j1_done_cnt", 64'(done_cnt), 64'd1);
        chk("j1_done_latency", 64'(done_cyc - ed_cyc), 64'd1);
        chk("j1_out_count", 64'(out_count), 64'd32768);
        chk("j1_errs", {62'd0, err_timeout, err_count}, 64'd0);
        chk("j1_idle", 64'(busy), 64'd0);

        // Job 2: hold every third cycle, engine stops after 100 outputs without done
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hold_en = 1'b1;
        eng_target = 100;
        eng_do_done = 1'b0;
        start_job(IMG_BASE, WGT_BASE);
        wait_done(30000, "j2");
        chk("j2_rd_cnt", 64'(rd_cnt), 64'd12520);
        chk("j2_valid_cnt", 64'(v_cnt), 64'd12288);
        chk("j2_bubbles", 64'((rel(last_cyc) - rel(v_first) + 1) > N), 64'd1);
        chk("j2_last_cnt", 64'(last_cnt), 64'd1);
        chk("j2_pix_err", 64'(pix_err), 64'd0);
        chk("j2_cfg_err", 64'(cfg_err), 64'd0);
        chk("j2_kernel", 64'(kernel === exp_kernel), 64'd1);
        chk("j2_bias_all", 64'(bias === exp_bias), 64'd1);
        chk("j2_done_cnt", 64'(done_cnt), 64'd1);
        chk("j2_timeout_latency", 64'(done_cyc - out_cyc), 64'(TIMEOUT + 1));
        chk("j2_out_count", 64'(out_count), 64'd100);
        chk("j2_err_timeout", 64'(err_timeout), 64'd1);
        chk("j2_err_count", 64'(err_count), 64'd1);

        // Job 3: reset mid-stream, then a fresh job with a short engine output run
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hold_en = 1'b0;
        eng_target = 5;
        eng_do_done = 1'b1;
        start_job(IMG_BASE, WGT_BASE);
        repeat (1300) tick();
        chk("j3_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        clr = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        clr = 1'b0;
        start_job(IMG_BASE, WGT_BASE);
        wait_done(20000, "j3");
        chk("j3_rd_cnt", 64'(rd_cnt), 64'd12520);
        chk("j3_first_valid", 64'(rel(v_first)), 64'd235);
        chk("j3_valid_cnt", 64'(v_cnt), 64'd12288);
        chk("j3_pix_err", 64'(pix_err), 64'd0);
        chk("j3_cfg_err", 64'(cfg_err), 64'd0);
        chk("j3_kernel", 64'(kernel === exp_kernel), 64'd1);
        chk("j3_done_cnt", 64'(done_cnt), 64'd1);
        chk("j3_done_latency", 64'(done_cyc - ed_cyc), 64'd1);
        chk("j3_out_count", 64'(out_count), 64'd5);
        chk("j3_err_timeout", 64'(err_timeout), 64'd0);
        chk("j3_err_count", 64'(err_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv2d_job_sequencer.md
# conv2d_job_sequencer

Controller in front of the multichannel 2-D convolution engine. On each `start` it:
- loads the engine's flat `kernel` and `bias` configuration from a byte-wide memory;
- streams the CIN×H×W input frame from the same memory into the engine as `pixel_in`/`valid_in`/`last_in`, channel-major;
- counts the engine's output pixels until the engine's `done` or a timeout.

It replaces testbench-style direct driving of the engine in the accelerator top level.

## Interface
Parameters:
- CIN, 3, input channels
- COUT, 8, output channels
- K, 3, kernel size
- H, 64, frame height
- W, 64, frame width
- DATA_W, 8, pixel/weight width
- BIAS_W, 16, bias width (multiple of 8)
- ADDR_W, 16, memory address width
- TIMEOUT, 4096, max idle cycles in DRAIN
- CNT_W, 16, width of out_count

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request, honoured only in IDLE
- img_base  in  ADDR_W  frame byte address, sampled on start
- wgt_base  in  ADDR_W  weight/bias byte address, sampled on start
- src_hold  in  1  stall: no memory read issued this cycle
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- kernel  out  COUT*CIN*K*K*DATA_W  engine weights
- bias  out  COUT*BIAS_W  engine biases
- eng_pixel  out  DATA_W  to engine pixel_in
- eng_valid  out  1  to engine valid_in
- eng_last  out  1  to engine last_in
- eng_valid_out  in  1  engine output strobe
- eng_done  in  1  engine completion
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- out_count  out  CNT_W  engine outputs seen this job
- err_timeout  out  1  job ended by timeout, held until next start
- err_count  out  1  out_count ≠ COUT*H*W at done, held until next start

## Operation
- Constants: NW=COUT*CIN*K*K; NB=COUT*BIAS_W/8; N=CIN*H*W.
- IDLE → LOAD_W on start.
  - Latch the base addresses.
  - Clear out_count and both error flags.
- LOAD_W: read wgt_base+j for j=0..NW-1. The returned byte j goes to kernel[j*DATA_W +: DATA_W].
- LOAD_B: read wgt_base+NW+b for b=0..NB-1. The returned byte b goes to bias[b*8 +: 8] (little-endian per bias).
- STREAM: read img_base+i for i=0..N-1.
  - The byte read for index i is registered onto eng_pixel with eng_valid=1.
  - eng_last=1 only with i=N-1.
  - → DRAIN after the last read issues.
- DRAIN: wait for eng_done.
  - The idle counter resets on each eng_valid_out.
  - eng_done=1 → DONE.
  - The idle counter reaching TIMEOUT → DONE with err_timeout=1.
- DONE: done=1 for one cycle, err_count evaluated, → IDLE.
- out_count increments on eng_valid_out in STREAM and DRAIN and saturates at all-ones.
- src_hold=1 in LOAD_W/LOAD_B/STREAM:
  - no read and no index advance that cycle;
  - produces eng_valid bubbles.
  - Reads already in flight still complete.
- kernel/bias change only during LOAD_W/LOAD_B. They are stable from the first eng_valid until the next start.
- start while busy: ignored.
- Reset (any time): state IDLE. All outputs 0, including kernel, bias, out_count and the error flags. The engine is reset by the same system reset.

## Timing
- Cycle 0 = the edge sampling start. With no holds:
  - mem_rd_en is high in cycles 1..NW+NB+N.
  - Read at cycle t → mem_rd_data at t+1 → eng_pixel/eng_valid at t+2 (output latency 2).
  - First eng_valid at cycle NW+NB+3; eng_last at cycle NW+NB+N+2.
  - Defaults: first eng_valid at 235, eng_last at 12522.
- The final bias byte is captured in the cycle of the first image read. It is therefore valid before the first eng_valid.
- done is asserted the cycle after eng_done is sampled high in DRAIN.
- Timeout: done asserted the cycle after the idle count equals TIMEOUT.
- eng_valid/eng_last/eng_pixel are registered. eng_valid is 0 outside STREAM and the 2-cycle tail after the last read.

## Structure
- Shared package conv_seq_pkg: state enum (IDLE, LOAD_W, LOAD_B, STREAM, DRAIN, DONE), NW/NB/N/OUT_TOTAL localparam functions, byte-lane index helpers.
- One sub-module, conv2d_cfg_capture: registers the kernel/bias bytes from a write strobe and a byte index.
- Top level holds the FSM, address counter, read pipeline, output counter and timeout counter.

## Test plan
- Default params, no holds, engine model emits 32768 outputs then done:
  - reads 1..12520;
  - first eng_valid at 235, eng_last at 12522 with byte N-1;
  - done once, out_count=32768, both errors 0.
- Weight memory holding the incrementing pattern 0x00..0xD7 then bias bytes 0x10..0x1F:
  - kernel byte j = j;
  - bias[15:0]=0x1110.
- src_hold high every third cycle through LOAD and STREAM:
  - identical kernel, bias and pixel sequence;
  - eng_valid count = 12288 with bubbles;
  - eng_last exactly once.
- Engine never asserts eng_done, stops outputs after 100:
  - done at TIMEOUT+1 cycles after the last output;
  - err_timeout=1, err_count=1, out_count=100.
- start pulsed mid-STREAM: ignored, addresses unaffected.
- rst_n low mid-STREAM: all outputs 0, state IDLE; a fresh start completes normally.
